obj_ram_scanner: RTL and testbench
==================================

OBJ_RAM_SCANNER -- requirements
Module: obj_ram_scanner

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_OBJ, default 256, giving the number of 8-byte object entries scanned; the legal range is 1..256.
REQ-002 The block SHALL have parameter SKIP_DISABLED, default 1; when 1, entries whose byte0 is 8'h00 SHALL NOT be emitted.

Ports:
REQ-003 i_MCLK  in  1  single clock; all state changes on its rising edge.
REQ-004 i_RST_n  in  1  reset, synchronous, active-low.
REQ-005 i_SCAN_START  in  1  one-cycle pulse that begins a scan; ignored while o_BUSY=1.
REQ-006 o_RAM_ADDR  out  11  object RAM address = {object index[7:0], byte[2:0]}.
REQ-007 o_RAM_RD_n  out  1  RAM read strobe, active-low.
REQ-008 i_RAM_DATA  in  8  RAM read data; valid on the cycle after the address/RD_n=0 cycle (registered-read SRAM).
REQ-009 o_OBJ_VALID  out  1  object record valid.
REQ-010 i_OBJ_READY  in  1  consumer accepts the record; a transfer occurs when VALID=1 and READY=1 at a clock edge.
REQ-011 o_OBJ_DATA  out  64  object record; byte n occupies bits [8n+7:8n].
REQ-012 o_OBJ_INDEX  out  8  index of the object in o_OBJ_DATA.
REQ-013 o_OBJ_COUNT  out  9  number of records transferred in the current or last scan.
REQ-014 o_BUSY  out  1  scan in progress.
REQ-015 o_DONE  out  1  one-cycle pulse when a scan completes.

Function
REQ-016 The FSM SHALL have these states and transitions:
- IDLE: on START, go to READ.
- READ: issue 8 byte reads, then go to LAST.
- LAST: capture byte7, then go to OUT or NEXT.
- OUT: wait for the handshake, then go to NEXT.
- NEXT: advance the index or finish.
REQ-017 IDLE: o_RAM_RD_n=1 and o_BUSY=0. On i_SCAN_START=1, the block SHALL clear the index and o_OBJ_COUNT, set o_BUSY=1 and enter READ on the next cycle.
REQ-018 READ: the block SHALL hold o_RAM_RD_n=0 for exactly 8 consecutive cycles, with o_RAM_ADDR={index, b} for b=0..7 in ascending order.
REQ-019 The byte addressed in cycle t SHALL be captured from i_RAM_DATA at the end of cycle t+1; byte7 is captured in LAST, where o_RAM_RD_n=1.
REQ-020 Each object SHALL take 9 cycles (READ + LAST) before the OUT/NEXT decision.
REQ-021 After LAST, the block SHALL go to OUT, except when SKIP_DISABLED=1 and the captured byte0 is 8'h00, in which case it SHALL go directly to NEXT with no record emitted.
REQ-022 OUT: o_OBJ_VALID=1, and o_OBJ_DATA and o_OBJ_INDEX SHALL be held stable until the handshake.
REQ-023 OUT: o_RAM_RD_n=1 throughout, so no RAM reads occur during backpressure.
REQ-024 On the handshake, the block SHALL drop VALID on the next cycle, increment o_OBJ_COUNT and enter NEXT.
REQ-025 NEXT (1 cycle): if index = NUM_OBJ-1, the block SHALL pulse o_DONE=1, set o_BUSY=0 and return to IDLE; otherwise it SHALL set index+1 and return to READ.
REQ-026 The index SHALL NOT wrap; a scan ends after NUM_OBJ-1. o_RAM_ADDR 11'h7FF is the final read when NUM_OBJ=256.
REQ-027 o_OBJ_COUNT SHALL saturate-free count to 256 (9 bits) and hold its value after DONE until the next accepted start.
REQ-028 i_SCAN_START during o_BUSY=1, including the NEXT cycle that asserts o_DONE, SHALL be ignored.
REQ-029 o_OBJ_VALID SHALL NOT depend combinationally on i_OBJ_READY.
REQ-030 The block SHALL never write the RAM.

Reset
REQ-031 While i_RST_n=0 at a clock edge, the following SHALL hold on the next cycle: state=IDLE, o_RAM_ADDR=0, o_RAM_RD_n=1, o_OBJ_VALID=0, o_OBJ_DATA=0, o_OBJ_INDEX=0, o_OBJ_COUNT=0, o_BUSY=0, o_DONE=0.
REQ-032 Reset mid-scan SHALL abandon the scan with no o_DONE pulse and no record emitted.

Verification
REQ-033 NUM_OBJ=2; RAM obj0 = 01..08, obj1 byte0 = 00; READY=1; START -> RD_n low cycles 1..8 at addr 0x000..0x007, then the following.
- One record with DATA=64'h0807060504030201, INDEX=0.
- obj1 is read (0x008..0x00F) but not emitted.
- DONE is pulsed, COUNT=1, BUSY=0.
REQ-034 Backpressure: READY=0 for 5 cycles while VALID=1 -> VALID, DATA and INDEX are stable and RD_n=1 for all 5 cycles; READY=1 -> the transfer occurs and the next object's reads start after the NEXT cycle.
REQ-035 NUM_OBJ=256, all byte0 nonzero, READY=1 -> 256 records with INDEX 0..255 ascending, the last read at 0x7FF, COUNT=256, exactly one DONE pulse, no wrap to index 0.
REQ-036 i_RST_n=0 for one cycle while reading object 10 -> all outputs at reset values the next cycle, no DONE; a new START rescans from address 0x000 and COUNT restarts at 0.
REQ-037 START pulses while BUSY, including on the DONE cycle, are ignored: no restart and no extra records.
REQ-038 SKIP_DISABLED=0 with obj byte0=00 -> the record is emitted with DATA[7:0]=00.

Source files
------------

// File: rtl/obj_ram_scanner.sv
// Walks the object RAM one 8-byte entry at a time and hands each entry to a
// consumer as a 64-bit record over a valid/ready handshake.
module obj_ram_scanner #(
    parameter int NUM_OBJ       = 256,
    parameter int SKIP_DISABLED = 1
) (
    input  logic        i_MCLK,
    input  logic        i_RST_n,
    input  logic        i_SCAN_START,
    output logic [10:0] o_RAM_ADDR,
    output logic        o_RAM_RD_n,
    input  logic [7:0]  i_RAM_DATA,
    output logic        o_OBJ_VALID,
    input  logic        i_OBJ_READY,
    output logic [63:0] o_OBJ_DATA,
    output logic [7:0]  o_OBJ_INDEX,
    output logic [8:0]  o_OBJ_COUNT,
    output logic        o_BUSY,
    output logic        o_DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_OUT,
        S_NEXT
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_OBJ - 1);

    state_t      state_reg;
    logic [7:0]  index_reg;
    logic [2:0]  byte_reg;
    logic [7:0]  cap_reg [0:6];
    logic [55:0] cap_flat;
    logic [10:0] addr_reg;
    logic        rd_n_reg;
    logic        valid_reg;
    logic [63:0] data_reg;
    logic [7:0]  obj_index_reg;
    logic [8:0]  count_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        skip_obj;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_pack
            assign cap_flat[8*gi +: 8] = cap_reg[gi];
        end
    endgenerate

    // byte0 was captured long before LAST, so the skip decision is ready in time
    assign skip_obj = (SKIP_DISABLED != 0) && (cap_reg[0] == 8'h00);

    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            state_reg     <= S_IDLE;
            index_reg     <= 8'd0;
            byte_reg      <= 3'd0;
            addr_reg      <= 11'd0;
            rd_n_reg      <= 1'b1;
            valid_reg     <= 1'b0;
            data_reg      <= 64'd0;
            obj_index_reg <= 8'd0;
            count_reg     <= 9'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                cap_reg[i] <= 8'd0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // a start landing on the DONE cycle belongs to the finished scan
                    if (i_SCAN_START && !done_reg) begin
                        index_reg <= 8'd0;
                        count_reg <= 9'd0;
                        busy_reg  <= 1'b1;
                        byte_reg  <= 3'd0;
                        addr_reg  <= 11'd0;
                        rd_n_reg  <= 1'b0;
                        state_reg <= S_READ;
                    end
                end
                S_READ: begin
                    if (byte_reg != 3'd0) begin
                        cap_reg[byte_reg - 3'd1] <= i_RAM_DATA;
                    end
                    if (byte_reg == 3'd7) begin
                        rd_n_reg  <= 1'b1;
                        state_reg <= S_LAST;
                    end else begin
                        byte_reg <= byte_reg + 3'd1;
                        addr_reg <= {index_reg, byte_reg + 3'd1};
                    end
                end
                S_LAST: begin
                    if (skip_obj) begin
                        state_reg <= S_NEXT;
                    end else begin
                        data_reg      <= {i_RAM_DATA, cap_flat};
                        obj_index_reg <= index_reg;
                        valid_reg     <= 1'b1;
                        state_reg     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_OBJ_READY) begin
                        valid_reg <= 1'b0;
                        count_reg <= count_reg + 9'd1;
                        state_reg <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (index_reg == LAST_IDX) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        index_reg <= index_reg + 8'd1;
                        byte_reg  <= 3'd0;
                        addr_reg  <= {index_reg + 8'd1, 3'd0};
                        rd_n_reg  <= 1'b0;
                        state_reg <= S_READ;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign o_RAM_ADDR  = addr_reg;
    assign o_RAM_RD_n  = rd_n_reg;
    assign o_OBJ_VALID = valid_reg;
    assign o_OBJ_DATA  = data_reg;
    assign o_OBJ_INDEX = obj_index_reg;
    assign o_OBJ_COUNT = count_reg;
    assign o_BUSY      = busy_reg;
    assign o_DONE      = done_reg;

endmodule

// File: tb/tb_obj_ram_scanner.sv
// Scoreboard bench for obj_ram_scanner: a full-size skipping instance driven
// with random RAM contents/backpressure, plus a small non-skipping instance.
module tb_obj_ram_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, rd_n, valid, ready, busy, done;
    logic [10:0] addr;
    logic [7:0]  ram_data = 8'h00;
    logic [63:0] data;
    logic [7:0]  idx;
    logic [8:0]  count;

    logic        start2, rd_n2, valid2, ready2, busy2, done2;
    logic [10:0] addr2;
    logic [7:0]  ram_data2 = 8'h00;
    logic [63:0] data2;
    logic [7:0]  idx2;
    logic [8:0]  count2;

    obj_ram_scanner #(.NUM_OBJ(256), .SKIP_DISABLED(1)) dut (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_SCAN_START(start),
        .o_RAM_ADDR(addr), .o_RAM_RD_n(rd_n), .i_RAM_DATA(ram_data),
        .o_OBJ_VALID(valid), .i_OBJ_READY(ready), .o_OBJ_DATA(data),
        .o_OBJ_INDEX(idx), .o_OBJ_COUNT(count), .o_BUSY(busy), .o_DONE(done)
    );

    obj_ram_scanner #(.NUM_OBJ(2), .SKIP_DISABLED(0)) dut2 (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_SCAN_START(start2),
        .o_RAM_ADDR(addr2), .o_RAM_RD_n(rd_n2), .i_RAM_DATA(ram_data2),
        .o_OBJ_VALID(valid2), .i_OBJ_READY(ready2), .o_OBJ_DATA(data2),
        .o_OBJ_INDEX(idx2), .o_OBJ_COUNT(count2), .o_BUSY(busy2), .o_DONE(done2)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  idx;
    } rec_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem  [0:2047];
    logic [7:0]  mem2 [0:15];
    rec_t        exp_q[$];
    rec_t        exp2_q[$];
    logic [10:0] rd_q[$];
    int          exp_total = 0;
    int          done_cnt = 0;
    int          done2_cnt = 0;
    int          ready_mode = 1;
    bit          held = 0;
    logic [63:0] held_data;
    logic [7:0]  held_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // registered-read SRAMs
    always @(posedge clk) if (!rd_n) ram_data <= mem[addr];
    always @(posedge clk) if (!rd_n2) ram_data2 <= mem2[addr2[3:0]];

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) ready = 1'($urandom_range(0, 1));
        else if (ready_mode == 1) ready = 1'b1;
    end

    // monitor for the main instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (!rd_n) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr %0h required no read", addr);
                end else begin
                    check("read_addr", addr, rd_q.pop_front());
                end
            end
            if (valid) begin
                check("rd_n_high_while_valid", rd_n, 1'b1);
                if (held) begin
                    check("hold_data", data, held_data);
                    check("hold_index", idx, held_idx);
                end
                if (ready) begin
                    held = 0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_record: got index %0d required none", idx);
                    end else begin
                        rec_t r;
                        r = exp_q.pop_front();
                        check("rec_data", data, r.data);
                        check("rec_index", idx, r.idx);
                        $display("record idx=%0d data=%016h", idx, data);
                    end
                end else begin
                    held = 1; held_data = data; held_idx = idx;
                end
            end else begin
                held = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_count", count, exp_total);
                check("done_busy_low", busy, 1'b0);
                check("done_records_left", exp_q.size(), 0);
                $display("scan done count=%0d", count);
            end
        end
    end

    // monitor for the non-skipping instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (!rd_n2) check("rd2_addr_range", addr2[10:4], 0);
            if (valid2 && ready2) begin
                if (exp2_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_record2: got index %0d required none", idx2);
                end else begin
                    rec_t r;
                    r = exp2_q.pop_front();
                    check("rec2_data", data2, r.data);
                    check("rec2_index", idx2, r.idx);
                    $display("record2 idx=%0d data=%016h", idx2, data2);
                end
            end
            if (done2) begin
                done2_cnt++;
                check("done2_count", count2, 2);
            end
        end
    end

    task automatic load_model(input bit all_nonzero, input bit directed);
        exp_q.delete();
        rd_q.delete();
        exp_total = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        for (int o = 0; o < 256; o++) begin
            if (all_nonzero) begin
                if (mem[o*8] == 8'h00) mem[o*8] = 8'h5A;
            end else if ($urandom_range(0, 3) == 0) begin
                mem[o*8] = 8'h00;
            end
        end
        if (directed) begin
            for (int b = 0; b < 8; b++) mem[b] = 8'(b + 1);
            mem[8] = 8'h00;
        end
        for (int o = 0; o < 256; o++) begin
            rec_t r;
            for (int b = 0; b < 8; b++) begin
                rd_q.push_back(11'(o * 8 + b));
                r.data[8*b +: 8] = mem[o*8 + b];
            end
            r.idx = 8'(o);
            if (mem[o*8] != 8'h00) begin
                exp_q.push_back(r);
                exp_total++;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("first_read_rd_n", rd_n, 1'b0);
        check("first_read_addr", addr, 11'h000);
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic run_scan(input int budget, input bit poke);
        int prev;
        int n;
        prev = done_cnt;
        n = 0;
        pulse_start();
        while (done_cnt == prev && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                check("start_on_done_busy", busy, 1'b0);
                check("start_on_done_rd_n", rd_n, 1'b1);
            end else begin
                start = (poke && busy && $urandom_range(0, 39) == 0);
            end
        end
        start = 1'b0;
        if (done_cnt == prev) begin
            checks++; errors++;
            $display("FAIL scan_timeout: got no DONE within %0d cycles required DONE", budget);
        end
        repeat (20) @(posedge clk);
        check("single_done_pulse", done_cnt, prev + 1);
        check("reads_left", rd_q.size(), 0);
    endtask

    initial begin
        int n;
        int prev_done;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; ready = 1'b1; ready2 = 1'b1;
        for (int i = 0; i < 16; i++) mem2[i] = 8'($urandom);
        mem2[0] = 8'h3C;
        mem2[8] = 8'h00;
        for (int o = 0; o < 2; o++) begin
            rec_t r;
            for (int b = 0; b < 8; b++) r.data[8*b +: 8] = mem2[o*8 + b];
            r.idx = 8'(o);
            exp2_q.push_back(r);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_addr", addr, 0);
        check("rst_rd_n", rd_n, 1'b1);
        check("rst_valid", valid, 1'b0);
        check("rst_data", data, 0);
        check("rst_index", idx, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        // small non-skipping instance: zero byte0 still emitted
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        n = 0;
        while (done2_cnt == 0 && n < 200) begin @(posedge clk); n++; end
        check("dut2_done_seen", done2_cnt, 1);
        check("dut2_records_left", exp2_q.size(), 0);
        check("dut2_busy_after", busy2, 1'b0);

        // random scan with a known first object and a disabled second one
        ready_mode = 0;
        load_model(1'b0, 1'b1);
        run_scan(8000, 1'b1);

        // backpressure on the first record, then reset while reading object 10
        ready_mode = 2; ready = 1'b0;
        load_model(1'b0, 1'b1);
        pulse_start();
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!valid && n < 200);
        check("bp_valid_arrives", valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", valid, 1'b1);
            check("bp_rd_n", rd_n, 1'b1);
            check("bp_data", data, 64'h0807060504030201);
            check("bp_index", idx, 0);
        end
        @(posedge clk); #1 ready = 1'b1; ready_mode = 1;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_dropped", valid, 1'b0);
        check("bp_next_idle", rd_n, 1'b1);
        @(negedge clk);
        check("bp_next_read", rd_n, 1'b0);
        check("bp_next_addr", addr, 11'h008);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(rd_n == 1'b0 && addr == 11'h053) && n < 2000);
        check("reached_obj10", addr, 11'h053);
        prev_done = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        rd_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("midrst_addr", addr, 0);
        check("midrst_rd_n", rd_n, 1'b1);
        check("midrst_valid", valid, 1'b0);
        check("midrst_data", data, 0);
        check("midrst_count", count, 0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        repeat (30) @(posedge clk);
        check("midrst_no_done", done_cnt, prev_done);

        // rescan after reset with random backpressure and stray starts
        ready_mode = 0;
        load_model(1'b0, 1'b0);
        run_scan(8000, 1'b1);

        // full scan, every entry enabled
        ready_mode = 1;
        load_model(1'b1, 1'b0);
        run_scan(8000, 1'b0);
        check("full_count", count, 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
